// File: rtl/bounce_sprite_engine_pkg.sv
// Shared types and constants for the bouncing-box engine.
// Colour width/values, direction encoding and FSM state encoding.
package bounce_sprite_engine_pkg;

  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

  // Direction of travel along one axis
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [2:0] {
    ST_INIT_DRAW = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ERASE     = 3'd2,
    ST_MOVE      = 3'd3,
    ST_DRAW      = 3'd4
  } state_t;

endpackage

// File: rtl/bounce_sprite_engine_frame_tick_gen.sv
// Free-running frame timebase: a 1-cycle frame_tick every CLKS_PER_FRAME
// clocks and a 1-cycle step_req every FRAMES_PER_STEP frame ticks.
// Ports: clock, resetn (sync, active-low), frame_tick, step_req.
module bounce_sprite_engine_frame_tick_gen #(
  parameter int unsigned CLKS_PER_FRAME  = 833333,
  parameter int unsigned FRAMES_PER_STEP = 15
) (
  input  logic clock,
  input  logic resetn,
  output logic frame_tick,
  output logic step_req
);

  localparam int unsigned TW = (CLKS_PER_FRAME  > 1) ? $clog2(CLKS_PER_FRAME)  : 1;
  localparam int unsigned FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] frame_cnt;
  logic          tick_wrap_c;
  logic          frame_wrap_c;

  assign tick_wrap_c  = (tick_cnt  == TW'(CLKS_PER_FRAME - 1));
  assign frame_wrap_c = (frame_cnt == FW'(FRAMES_PER_STEP - 1));

  // Clock and frame counters; both pulses are registered
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tick_cnt   <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      step_req   <= 1'b0;
    end else begin
      tick_cnt   <= tick_wrap_c ? '0 : tick_cnt + TW'(1);
      if (tick_wrap_c) begin
        frame_cnt <= frame_wrap_c ? '0 : frame_cnt + FW'(1);
      end
      frame_tick <= tick_wrap_c;
      step_req   <= tick_wrap_c && frame_wrap_c;
    end
  end

endmodule

// File: rtl/bounce_sprite_engine.sv
// Bouncing-box engine driving the pixel-write side of a VGA adapter.
// Each motion step erases the box, moves it diagonally (reflecting off the
// screen edges) and redraws it, one pixel write per cycle.
// Ports: clock, resetn (sync, active-low), go, ld_colour, colour_in,
//        plot_x/plot_y/plot_colour/plot (adapter write bus), busy,
//        bounce_count (saturating wall-reflection count).
module bounce_sprite_engine
  import bounce_sprite_engine_pkg::*;
#(
  parameter int unsigned SCREEN_W        = 160,
  parameter int unsigned SCREEN_H        = 120,
  parameter int unsigned X_W             = 8,
  parameter int unsigned Y_W             = 7,
  parameter int unsigned BOX_W           = 4,
  parameter int unsigned BOX_H           = 4,
  parameter int unsigned STEP            = 1,
  parameter int unsigned CLKS_PER_FRAME  = 833333,
  parameter int unsigned FRAMES_PER_STEP = 15,
  parameter int unsigned INIT_X          = 0,
  parameter int unsigned INIT_Y          = 60
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                go,
  input  logic                ld_colour,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot,
  output logic                busy,
  output logic [7:0]          bounce_count
);

  localparam int unsigned MAXX = SCREEN_W - BOX_W;
  localparam int unsigned MAXY = SCREEN_H - BOX_H;
  localparam int unsigned XE   = X_W + 1;
  localparam int unsigned YE   = Y_W + 1;

  state_t              state, next_state;
  logic [X_W-1:0]      pos_x, px, next_x;
  logic [Y_W-1:0]      pos_y, py, next_y;
  logic                dir_x, dir_y, next_dir_x, next_dir_y;
  logic                flip_x_c, flip_y_c;
  logic [COLOUR_W-1:0] box_colour, phase_colour, scan_colour_c;
  logic                pending, step_req, frame_tick_unused;
  logic                scan_en_c, scan_first_c, scan_last_c, draw_phase_c, busy_next_c;

  // frame_tick is available for debug; only step_req drives motion
  bounce_sprite_engine_frame_tick_gen #(
    .CLKS_PER_FRAME (CLKS_PER_FRAME),
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_tick (
    .clock     (clock),
    .resetn    (resetn),
    .frame_tick(frame_tick_unused),
    .step_req  (step_req)
  );

  assign scan_first_c = (px == '0) && (py == '0);
  assign scan_last_c  = (px == X_W'(BOX_W - 1)) && (py == Y_W'(BOX_H - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_INIT_DRAW;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT_DRAW: if (scan_last_c) next_state = ST_IDLE;
      ST_IDLE:      if (go && (step_req || pending)) next_state = ST_ERASE;
      ST_ERASE:     if (scan_last_c) next_state = ST_MOVE;
      ST_MOVE:      next_state = ST_DRAW;
      ST_DRAW:      if (scan_last_c) next_state = ST_IDLE;
      default:      next_state = ST_INIT_DRAW;
    endcase
  end

  // Output decode; draw colour is sampled once at the first pixel of a phase
  always_comb begin
    scan_en_c     = 1'b0;
    draw_phase_c  = 1'b0;
    scan_colour_c = COLOUR_BLACK;
    busy_next_c   = (next_state != ST_IDLE);
    case (state)
      ST_INIT_DRAW, ST_DRAW: begin
        scan_en_c     = 1'b1;
        draw_phase_c  = 1'b1;
        scan_colour_c = scan_first_c ? box_colour : phase_colour;
      end
      ST_ERASE: scan_en_c = 1'b1;
      default: ;
    endcase
  end

  // X-axis move with reflection; an exact edge landing flips direction
  always_comb begin
    next_x     = pos_x;
    next_dir_x = dir_x;
    flip_x_c   = 1'b0;
    if (dir_x == DIR_POS) begin
      if (XE'(pos_x) + XE'(STEP) >= XE'(MAXX)) begin
        next_x     = X_W'(MAXX);
        next_dir_x = DIR_NEG;
        flip_x_c   = 1'b1;
      end else begin
        next_x = X_W'(XE'(pos_x) + XE'(STEP));
      end
    end else begin
      if (XE'(pos_x) <= XE'(STEP)) begin
        next_x     = '0;
        next_dir_x = DIR_POS;
        flip_x_c   = 1'b1;
      end else begin
        next_x = X_W'(XE'(pos_x) - XE'(STEP));
      end
    end
  end

  // Y-axis move with reflection
  always_comb begin
    next_y     = pos_y;
    next_dir_y = dir_y;
    flip_y_c   = 1'b0;
    if (dir_y == DIR_POS) begin
      if (YE'(pos_y) + YE'(STEP) >= YE'(MAXY)) begin
        next_y     = Y_W'(MAXY);
        next_dir_y = DIR_NEG;
        flip_y_c   = 1'b1;
      end else begin
        next_y = Y_W'(YE'(pos_y) + YE'(STEP));
      end
    end else begin
      if (YE'(pos_y) <= YE'(STEP)) begin
        next_y     = '0;
        next_dir_y = DIR_POS;
        flip_y_c   = 1'b1;
      end else begin
        next_y = Y_W'(YE'(pos_y) - YE'(STEP));
      end
    end
  end

  // Pixel scanner and registered plot bus
  always_ff @(posedge clock) begin
    if (!resetn) begin
      px          <= '0;
      py          <= '0;
      plot        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      busy        <= 1'b0;
    end else begin
      plot <= scan_en_c;
      busy <= busy_next_c;
      if (scan_en_c) begin
        plot_x      <= pos_x + px;
        plot_y      <= pos_y + py;
        plot_colour <= scan_colour_c;
        if (scan_last_c) begin
          px <= '0;
          py <= '0;
        end else if (px == X_W'(BOX_W - 1)) begin
          px <= '0;
          py <= py + Y_W'(1);
        end else begin
          px <= px + X_W'(1);
        end
      end
    end
  end

  // Position, direction, bounce counter
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pos_x        <= X_W'(INIT_X);
      pos_y        <= Y_W'(INIT_Y);
      dir_x        <= DIR_POS;
      dir_y        <= DIR_POS;
      bounce_count <= '0;
    end else if (state == ST_MOVE) begin
      pos_x <= next_x;
      pos_y <= next_y;
      dir_x <= next_dir_x;
      dir_y <= next_dir_y;
      if ((flip_x_c || flip_y_c) && (bounce_count != 8'hFF)) begin
        bounce_count <= bounce_count + 8'd1;
      end
    end
  end

  // Colour registers and single-deep step queue
  always_ff @(posedge clock) begin
    if (!resetn) begin
      box_colour   <= COLOUR_WHITE;
      phase_colour <= COLOUR_WHITE;
      pending      <= 1'b0;
    end else begin
      if (ld_colour) box_colour <= colour_in;
      if (scan_first_c && draw_phase_c) phase_colour <= box_colour;
      // IDLE either consumes or discards any queued request
      if (state == ST_IDLE) pending <= 1'b0;
      else if (step_req)    pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Directed bench for bounce_sprite_engine on a small 16x12 screen (dut) and
// a 12x12 screen for the corner bounce (dut2).
module tb_bounce_sprite_engine;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;

  logic           clock;
  logic           resetn, go, ld_colour;
  logic [2:0]     colour_in;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [2:0]     plot_colour;
  logic           plot, busy;
  logic [7:0]     bounce_count;

  logic           go2;
  logic [X_W-1:0] plot_x2;
  logic [Y_W-1:0] plot_y2;
  logic [2:0]     plot_colour2;
  logic           plot2, busy2;
  logic [7:0]     bounce_count2;

  int checks = 0;
  int errors = 0;

  // Expected position / bounce count after step k (hand-derived, MAXX=14, MAXY=10)
  int exp_x  [0:18] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,13,12,11,10};
  int exp_y  [0:18] = '{5,6,7,8,9,10,9,8,7,6,5,4,3,2,1,0,1,2,3};
  int exp_bc [0:18] = '{0,0,0,0,0,1,1,1,1,1,1,1,1,1,2,3,3,3,3};

  bounce_sprite_engine #(
    .SCREEN_W(16), .SCREEN_H(12), .X_W(X_W), .Y_W(Y_W), .BOX_W(2), .BOX_H(2),
    .STEP(1), .CLKS_PER_FRAME(4), .FRAMES_PER_STEP(2), .INIT_X(0), .INIT_Y(5)
  ) dut (
    .clock(clock), .resetn(resetn), .go(go), .ld_colour(ld_colour),
    .colour_in(colour_in), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .plot(plot), .busy(busy),
    .bounce_count(bounce_count)
  );

  bounce_sprite_engine #(
    .SCREEN_W(12), .SCREEN_H(12), .X_W(X_W), .Y_W(Y_W), .BOX_W(2), .BOX_H(2),
    .STEP(1), .CLKS_PER_FRAME(4), .FRAMES_PER_STEP(2), .INIT_X(0), .INIT_Y(0)
  ) dut2 (
    .clock(clock), .resetn(resetn), .go(go2), .ld_colour(1'b0),
    .colour_in(3'b000), .plot_x(plot_x2), .plot_y(plot_y2),
    .plot_colour(plot_colour2), .plot(plot2), .busy(busy2),
    .bounce_count(bounce_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Captures one 2x2 phase on dut starting at (ex,ey); optional colour load
  // after pixel ld_at, optional reset assertion after pixel abort_at.
  task automatic capture(input string tag, input int ex, input int ey,
                         input logic [2:0] ec, input int ld_at, input int abort_at);
    int n;
    logic [18:0] obs, expv;
    n = 0;
    while (plot !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    assert (plot === 1'b1) else begin
      errors++;
      $error("FAIL %s_start plot=%b expected 1", tag, plot);
    end
    for (int i = 0; i < 4; i++) begin
      obs  = {plot, plot_x, plot_y, plot_colour};
      expv = {1'b1, X_W'(ex + (i % 2)), Y_W'(ey + (i / 2)), ec};
      checks++;
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s_px%0d got plot=%b x=%0d y=%0d c=%0d expected plot=1 x=%0d y=%0d c=%0d",
               tag, i, plot, plot_x, plot_y, plot_colour, ex + (i % 2), ey + (i / 2), ec);
      end
      ld_colour = 1'b0;
      if (i == ld_at) begin
        ld_colour = 1'b1;
        colour_in = 3'b100;
      end
      if (i == abort_at) begin
        resetn = 1'b0;
        return;
      end
      @(negedge clock);
    end
    ld_colour = 1'b0;
  endtask

  // Waits on dut2 for plot2 to reach lvl, bounded
  task automatic wait_plot2(input string tag, input logic lvl);
    int n;
    n = 0;
    while (plot2 !== lvl && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    assert (plot2 === lvl) else begin
      errors++;
      $error("FAIL %s plot2=%b expected %b", tag, plot2, lvl);
    end
  endtask

  initial begin
    int n;
    logic quiet;
    logic [18:0] obs2, exp2;
    resetn    = 1'b0;
    go        = 1'b0;
    go2       = 1'b0;
    ld_colour = 1'b0;
    colour_in = 3'b000;
    repeat (3) @(negedge clock);

    // Reset state
    checks++; assert (plot === 1'b0) else begin errors++; $error("FAIL rst_plot got %b expected 0", plot); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy got %b expected 0", busy); end
    checks++; assert (bounce_count === 8'd0) else begin errors++; $error("FAIL rst_bc got %0d expected 0", bounce_count); end
    checks++; assert ({plot_x, plot_y, plot_colour} === 18'd0) else begin
      errors++; $error("FAIL rst_bus got x=%0d y=%0d c=%0d expected 0", plot_x, plot_y, plot_colour);
    end

    // Initial draw, then nothing while paused
    resetn = 1'b1;
    capture("init", 0, 5, 3'b111, -1, -1);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (plot !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      @(negedge clock);
    end
    checks++; assert (quiet === 1'b1) else begin errors++; $error("FAIL paused_quiet got %b expected 1", quiet); end
    checks++; assert (bounce_count === 8'd0) else begin errors++; $error("FAIL paused_bc got %0d expected 0", bounce_count); end

    // Motion: edges, bounces, colour load mid-DRAW
    go = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      capture($sformatf("erase%0d", k), exp_x[k-1], exp_y[k-1], 3'b000, -1, -1);
      capture($sformatf("draw%0d", k), exp_x[k], exp_y[k], (k == 18) ? 3'b100 : 3'b111,
              (k == 17) ? 1 : -1, -1);
      checks++;
      assert (bounce_count === 8'(exp_bc[k])) else begin
        errors++; $error("FAIL bc_step%0d got %0d expected %0d", k, bounce_count, exp_bc[k]);
      end
    end

    // Reset in the middle of an ERASE
    capture("abort", exp_x[18], exp_y[18], 3'b000, -1, 1);
    @(negedge clock);
    resetn = 1'b1;
    go     = 1'b0;
    checks++; assert (plot === 1'b0) else begin errors++; $error("FAIL abort_plot got %b expected 0", plot); end
    checks++; assert (bounce_count === 8'd0) else begin errors++; $error("FAIL abort_bc got %0d expected 0", bounce_count); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL abort_busy got %b expected 0", busy); end
    capture("redraw", 0, 5, 3'b111, -1, -1);

    // Corner bounce on the 12x12 screen
    go2 = 1'b1;
    n = 0;
    while (bounce_count2 === 8'd0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++; assert (bounce_count2 === 8'd1) else begin
      errors++; $error("FAIL corner_bc got %0d expected 1", bounce_count2);
    end
    wait_plot2("corner_draw", 1'b1);
    obs2 = {plot2, plot_x2, plot_y2, plot_colour2};
    exp2 = {1'b1, 8'd10, 7'd10, 3'b111};
    checks++; assert (obs2 === exp2) else begin
      errors++; $error("FAIL corner_pos got x=%0d y=%0d c=%0d expected x=10 y=10 c=7", plot_x2, plot_y2, plot_colour2);
    end
    wait_plot2("corner_gap1", 1'b0);
    wait_plot2("corner_erase", 1'b1);
    obs2 = {plot2, plot_x2, plot_y2, plot_colour2};
    exp2 = {1'b1, 8'd10, 7'd10, 3'b000};
    checks++; assert (obs2 === exp2) else begin
      errors++; $error("FAIL corner_erase got x=%0d y=%0d c=%0d expected x=10 y=10 c=0", plot_x2, plot_y2, plot_colour2);
    end
    wait_plot2("corner_gap2", 1'b0);
    wait_plot2("after_corner", 1'b1);
    obs2 = {plot2, plot_x2, plot_y2, plot_colour2};
    exp2 = {1'b1, 8'd9, 7'd9, 3'b111};
    checks++; assert (obs2 === exp2) else begin
      errors++; $error("FAIL after_corner got x=%0d y=%0d c=%0d expected x=9 y=9 c=7", plot_x2, plot_y2, plot_colour2);
    end
    checks++; assert (bounce_count2 === 8'd1) else begin
      errors++; $error("FAIL corner_once got %0d expected 1", bounce_count2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
